// File: rtl/fsk4_demodulator.sv
// fsk4_demodulator: 4-FSK receiver. Hunts for a run of constant marker
// samples, then counts rising zero crossings in fixed-length windows and
// maps each count to a 2-bit symbol.
// Optional build macro FSK_DEMOD_ERRCNT_EN enables the ambiguous-symbol
// counter on err_count; without it err_count is constant zero.
module fsk4_demodulator #(
  parameter int          SYNC_MIN   = 8,
  parameter int          SYMBOL_LEN = 1000,
  parameter logic [17:0] MARKER     = 18'h0FFFF,
  parameter int          TH0        = 15,
  parameter int          TH1        = 25,
  parameter int          TH2        = 35,
  parameter int          GUARD      = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic signed [17:0] sample_in,
  input  logic               sample_valid,
  output logic [1:0]         symbol_out,
  output logic               symbol_valid,
  output logic               locked,
  output logic [15:0]        err_count
);

  localparam int SCNT_W = $clog2(SYMBOL_LEN + 1);

  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // Saturating 8-bit increment shared by the marker run and crossing counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Crossing count to symbol mapping.
  function automatic logic [1:0] decide(input logic [7:0] cnt);
    int c;
    c = int'(cnt);
    if (c < TH0)      return 2'd0;
    else if (c < TH1) return 2'd1;
    else if (c < TH2) return 2'd2;
    else              return 2'd3;
  endfunction

  logic [1:0]        r_state;
  logic [7:0]        r_run;
  logic [7:0]        r_xcnt;
  logic [SCNT_W-1:0] r_scnt;
  logic              r_prev_sign;
  logic [1:0]        r_symbol;
  logic              r_symbol_valid;
  logic              r_locked;

  logic              w_marker;
  logic              w_sign;
  logic              w_cross;
  logic [7:0]        w_xcnt_next;
  logic              w_last;
  logic [1:0]        w_sym;

  // Per-sample decode: marker test, rising crossing, count including this sample.
  always_comb begin
    w_marker    = ($unsigned(sample_in) == MARKER);
    w_sign      = sample_in[17];
    w_cross     = r_prev_sign & ~w_sign;
    w_xcnt_next = w_cross ? sat_inc8(r_xcnt) : r_xcnt;
    w_last      = (r_scnt == SCNT_W'(SYMBOL_LEN - 1));
    w_sym       = decide(w_xcnt_next);
  end

  // Sync/data state machine, window counters and registered symbol outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_HUNT;
      r_run          <= '0;
      r_xcnt         <= '0;
      r_scnt         <= '0;
      r_prev_sign    <= 1'b0;
      r_symbol       <= '0;
      r_symbol_valid <= 1'b0;
      r_locked       <= 1'b0;
    end else begin
      r_symbol_valid <= 1'b0;
      if (sample_valid) begin
        case (r_state)
          ST_HUNT: begin
            if (w_marker) begin
              r_state <= ST_SYNC;
              r_run   <= 8'd1;
            end
          end
          ST_SYNC: begin
            if (w_marker) begin
              r_run <= sat_inc8(r_run);
            end else if (r_run >= 8'(SYNC_MIN)) begin
              // First non-marker is already sample 1 of the first window.
              r_state     <= ST_DATA;
              r_locked    <= 1'b1;
              r_prev_sign <= w_sign;
              r_xcnt      <= '0;
              r_scnt      <= SCNT_W'(1);
            end else begin
              r_state <= ST_HUNT;
              r_run   <= '0;
            end
          end
          ST_DATA: begin
            if (w_marker) begin
              // Resync wins over any partial or completing window.
              r_state  <= ST_SYNC;
              r_run    <= 8'd1;
              r_locked <= 1'b0;
            end else begin
              r_prev_sign <= w_sign;
              if (w_last) begin
                r_xcnt         <= '0;
                r_scnt         <= '0;
                r_symbol       <= w_sym;
                r_symbol_valid <= 1'b1;
              end else begin
                r_xcnt <= w_xcnt_next;
                r_scnt <= r_scnt + SCNT_W'(1);
              end
            end
          end
          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign symbol_out   = r_symbol;
  assign symbol_valid = r_symbol_valid;
  assign locked       = r_locked;

`ifdef FSK_DEMOD_ERRCNT_EN
  // True when the count lies within GUARD of any decision threshold.
  function automatic logic is_ambiguous(input logic [7:0] cnt);
    int c;
    c = int'(cnt);
    return ((c >= TH0 - GUARD) && (c <= TH0 + GUARD)) ||
           ((c >= TH1 - GUARD) && (c <= TH1 + GUARD)) ||
           ((c >= TH2 - GUARD) && (c <= TH2 + GUARD));
  endfunction

  logic        w_decide;
  logic [15:0] r_err_count;

  assign w_decide = sample_valid && (r_state == ST_DATA) && !w_marker && w_last;

  // Saturating count of decisions that landed near a threshold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_count <= '0;
    end else if (w_decide && is_ambiguous(w_xcnt_next) && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`else
  // Counter absent: GUARD is referenced only so both builds keep one
  // parameter list; the result is always zero.
  assign err_count = 16'(GUARD) & 16'h0000;
`endif

endmodule

// File: tb/tb_fsk4_demodulator.sv
// Directed bench for fsk4_demodulator: table of back-to-back symbol windows
// plus hand-written sequences for sync loss, marker-on-last-sample,
// gapped valid, async reset and the optional ambiguity counter.
module tb_fsk4_demodulator;

  localparam logic signed [17:0] MARK = 18'sh0FFFF;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic signed [17:0] sample_in = '0;
  logic               sample_valid = 1'b0;
  logic [1:0]         symbol_out;
  logic               symbol_valid;
  logic               locked;
  logic [15:0]        err_count;

  int         checks = 0;
  int         errors = 0;
  int         vcount = 0;
  int         cyc_cnt = 0;
  int         n_pulses = 0;
  int         last_pulse_v = 0;
  int         last_pulse_c = 0;
  logic [1:0] last_sym = '0;
  logic       prev_sv = 1'b0;
  int         dbl_pulse = 0;
  logic       saw_locked = 1'b0;

  typedef struct {
    int         cyc;
    logic [1:0] exp_sym;
  } win_t;
  win_t wins[4];

  fsk4_demodulator dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .symbol_out   (symbol_out),
    .symbol_valid (symbol_valid),
    .locked       (locked),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Square wave with exactly cyc rising edges per 1000 samples, starting at phase 0.
  function automatic logic signed [17:0] sq(input int cyc, input int k);
    return (((k * cyc) % 1000) < 500) ? 18'sd20000 : -18'sd20000;
  endfunction

  task automatic step(input logic signed [17:0] s, input logic v);
    @(negedge clk);
    sample_in    = s;
    sample_valid = v;
    @(posedge clk);
    #1;
    cyc_cnt++;
    if (v) vcount++;
    if (symbol_valid) begin
      if (prev_sv) dbl_pulse++;
      n_pulses++;
      last_sym     = symbol_out;
      last_pulse_v = vcount;
      last_pulse_c = cyc_cnt;
    end
    prev_sv = symbol_valid;
    if (locked) saw_locked = 1'b1;
  endtask

  task automatic markers(input int n);
    for (int i = 0; i < n; i++) step(MARK, 1'b1);
  endtask

  task automatic wave(input int cyc, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) step(sq(cyc, k), 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    prev_sv = 1'b0;
  endtask

  initial begin
    int p0;
    int base;
    int pv;
    int c0;

    wins[0] = '{cyc: 10, exp_sym: 2'd0};
    wins[1] = '{cyc: 20, exp_sym: 2'd1};
    wins[2] = '{cyc: 30, exp_sym: 2'd2};
    wins[3] = '{cyc: 40, exp_sym: 2'd3};

    // Reset values
    #2 reset_n = 1'b0;
    #1;
    chk("rst_symbol_out", symbol_out, 0);
    chk("rst_symbol_valid", symbol_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_count", err_count, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 10 markers then a 20-cycle window: symbol 1 after sample 1000
    markers(10);
    chk("t1_unlocked_in_sync", locked, 0);
    p0   = n_pulses;
    base = vcount;
    step(sq(20, 0), 1'b1);
    chk("t1_locked_after_first_data", locked, 1);
    wave(20, 1, 998);
    chk("t1_no_early_pulse", n_pulses - p0, 0);
    step(sq(20, 999), 1'b1);
    chk("t1_one_pulse", n_pulses - p0, 1);
    chk("t1_symbol", last_sym, 1);
    chk("t1_pulse_at_sample_1000", last_pulse_v - base, 1000);

    // Back-to-back windows from the table
    for (int i = 0; i < 4; i++) begin
      p0 = n_pulses;
      pv = last_pulse_v;
      wave(wins[i].cyc, 0, 1000);
      chk($sformatf("win%0d_pulses", i), n_pulses - p0, 1);
      chk($sformatf("win%0d_symbol", i), last_sym, wins[i].exp_sym);
      chk($sformatf("win%0d_spacing", i), last_pulse_v - pv, 1000);
    end
    step(sq(10, 0), 1'b1);
    chk("hold_symbol_out", symbol_out, 3);
    chk("hold_no_pulse", symbol_valid, 0);
    chk("no_ambiguous_so_far", err_count, 0);

    // Too few markers: stays hunting
    pulse_reset();
    markers(5);
    saw_locked = 1'b0;
    p0 = n_pulses;
    wave(20, 0, 1100);
    chk("short_sync_never_locked", saw_locked, 0);
    chk("short_sync_no_pulse", n_pulses - p0, 0);

    // Partial symbol discarded by markers, then relock
    markers(10);
    wave(20, 0, 400);
    chk("t4_locked", locked, 1);
    p0 = n_pulses;
    markers(1);
    chk("t4_lock_drops", locked, 0);
    markers(9);
    chk("t4_no_partial_pulse", n_pulses - p0, 0);
    step(sq(40, 0), 1'b1);
    chk("t4_relocked", locked, 1);
    wave(40, 1, 999);
    chk("t4_pulse", n_pulses - p0, 1);
    chk("t4_symbol", last_sym, 3);

    // Marker on the last sample of a window: no symbol
    p0 = n_pulses;
    wave(20, 0, 999);
    step(MARK, 1'b1);
    chk("t5_marker_wins_no_pulse", n_pulses - p0, 0);
    chk("t5_lock_drops", locked, 0);
    markers(7);
    wave(30, 0, 1000);
    chk("t5_relock_pulse", n_pulses - p0, 1);
    chk("t5_symbol", last_sym, 2);

    // 50% sample_valid; invalid cycles carry marker values that must be ignored
    pulse_reset();
    markers(10);
    p0 = n_pulses;
    c0 = cyc_cnt;
    for (int k = 0; k < 1000; k++) begin
      step(sq(30, k), 1'b1);
      if (k != 999) step(MARK, 1'b0);
    end
    chk("t6_pulse", n_pulses - p0, 1);
    chk("t6_symbol", last_sym, 2);
    chk("t6_pulse_clock", last_pulse_c - c0, 1999);
    step(MARK, 1'b0);
    chk("t6_pulse_one_cycle", symbol_valid, 0);
    chk("t6_still_locked", locked, 1);

    // Async reset mid-window
    wave(30, 0, 500);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_symbol_out", symbol_out, 0);
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_symbol_valid", symbol_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    prev_sv = 1'b0;
    saw_locked = 1'b0;
    p0 = n_pulses;
    wave(30, 500, 500);
    chk("t6_hunt_after_reset", saw_locked, 0);
    chk("t6_no_pulse_after_reset", n_pulses - p0, 0);

    // 24-crossing window: symbol 1, ambiguous near TH1
    pulse_reset();
    markers(10);
    p0 = n_pulses;
    wave(25, 0, 1000);
    chk("t7_pulse", n_pulses - p0, 1);
    chk("t7_symbol", last_sym, 1);
`ifdef FSK_DEMOD_ERRCNT_EN
    chk("t7_err_count", err_count, 1);
`else
    chk("t7_err_count", err_count, 0);
`endif

    chk("single_cycle_pulses", dbl_pulse, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
